// File: rtl/alu_seq_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_muldiv
// Brief    : WIDTH-bit sequential ALU. Single-cycle AND/OR/ADD/SUB/SLT plus
//            iterative unsigned shift-add multiply and restoring divide,
//            with a start/busy/done handshake and registered results.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_first,
  input  logic [WIDTH-1:0] i_second,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_result_hi,
  output logic             o_zero,
  output logic             o_overflow,
  output logic             o_div_by_zero,
  output logic             o_busy,
  output logic             o_done
);

  localparam int             c_CW       = $clog2(WIDTH + 1);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH);

  localparam logic [2:0] c_OP_AND   = 3'b000;
  localparam logic [2:0] c_OP_OR    = 3'b001;
  localparam logic [2:0] c_OP_ADD   = 3'b010;
  localparam logic [2:0] c_OP_MULTU = 3'b011;
  localparam logic [2:0] c_OP_DIVU  = 3'b100;
  localparam logic [2:0] c_OP_SUB   = 3'b110;
  localparam logic [2:0] c_OP_SLT   = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Iteration state: r_acc holds {partial product, multiplier} for MULTU or
  // {partial remainder, dividend/quotient} for DIVU; r_opnd is the fixed
  // multiplicand or divisor.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic [c_CW-1:0]    r_cnt;

  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_zero;
  logic               r_overflow;
  logic               r_div_by_zero;
  logic               r_done;

  logic               w_accept;
  logic               w_is_divu;
  logic               w_go_run;
  logic [c_CW-1:0]    w_cnt_inc;
  logic               w_last;

  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic               w_slt;
  logic [WIDTH-1:0]   w_sc_lo;
  logic [WIDTH-1:0]   w_sc_hi;
  logic               w_sc_ov;
  logic               w_sc_dbz;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ok;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_accept  = i_start && (r_state == S_IDLE);
  assign w_is_divu = (i_op == c_OP_DIVU);
  // A divide by zero never enters RUN; it completes with the fixed result.
  assign w_go_run  = w_accept && ((i_op == c_OP_MULTU) ||
                                  (w_is_divu && (i_second != '0)));
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_last    = (r_state == S_RUN) && (w_cnt_inc == c_CNT_LAST);

  assign w_sum  = i_first + i_second;
  assign w_diff = i_first - i_second;
  assign w_slt  = $signed(i_first) < $signed(i_second);

  // One shift-add multiply step: add multiplicand if multiplier LSB set,
  // then shift the whole accumulator right by one (carry enters the top).
  assign w_addend   = r_acc[0] ? r_opnd : {WIDTH{1'b0}};
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // One restoring divide step: shift next dividend bit into the remainder,
  // trial-subtract the divisor; bit WIDTH of the difference is the borrow.
  assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_ok    = ~w_div_diff[WIDTH];
  assign w_div_rem   = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
  assign w_div_next  = {w_div_rem, r_acc[WIDTH-2:0], w_div_ok};

  assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

  // Single-cycle results, computed straight from the operands being accepted.
  always_comb begin
    w_sc_lo  = '0;
    w_sc_hi  = '0;
    w_sc_ov  = 1'b0;
    w_sc_dbz = 1'b0;
    case (i_op)
      c_OP_AND: w_sc_lo = i_first & i_second;
      c_OP_OR:  w_sc_lo = i_first | i_second;
      c_OP_ADD: begin
        w_sc_lo = w_sum;
        w_sc_ov = (i_first[WIDTH-1] == i_second[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != i_first[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_sc_lo = w_diff;
        w_sc_ov = (i_first[WIDTH-1] != i_second[WIDTH-1]) &&
                  (w_diff[WIDTH-1] != i_first[WIDTH-1]);
      end
      c_OP_SLT: w_sc_lo = {{(WIDTH-1){1'b0}}, w_slt};
      c_OP_DIVU: begin
        w_sc_lo  = '1;
        w_sc_hi  = i_first;
        w_sc_dbz = 1'b1;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state: enter RUN for a multi-cycle op, leave after the last step.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_go_run) w_state_next = S_RUN;
      S_RUN:   if (w_last)   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands on acceptance, iterate in RUN, and update the
  // visible outputs only on completion so partial values never leak out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc         <= '0;
      r_opnd        <= '0;
      r_is_div      <= 1'b0;
      r_cnt         <= '0;
      r_result      <= '0;
      r_result_hi   <= '0;
      r_zero        <= 1'b1;
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_cnt <= '0;
        if (w_go_run) begin
          r_is_div <= w_is_divu;
          r_opnd   <= w_is_divu ? i_second : i_first;
          r_acc    <= {{WIDTH{1'b0}}, (w_is_divu ? i_first : i_second)};
        end else begin
          r_result      <= w_sc_lo;
          r_result_hi   <= w_sc_hi;
          r_zero        <= (w_sc_lo == '0);
          r_overflow    <= w_sc_ov;
          r_div_by_zero <= w_sc_dbz;
          r_done        <= 1'b1;
        end
      end else if (r_state == S_RUN) begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_inc;
        if (w_last) begin
          r_result      <= w_acc_next[WIDTH-1:0];
          r_result_hi   <= w_acc_next[2*WIDTH-1:WIDTH];
          r_zero        <= (w_acc_next[WIDTH-1:0] == '0);
          r_overflow    <= 1'b0;
          r_div_by_zero <= 1'b0;
          r_done        <= 1'b1;
        end
      end
    end
  end

  assign o_result      = r_result;
  assign o_result_hi   = r_result_hi;
  assign o_zero        = r_zero;
  assign o_overflow    = r_overflow;
  assign o_div_by_zero = r_div_by_zero;
  assign o_busy        = (r_state == S_RUN);
  assign o_done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_muldiv
// Brief    : Self-checking bench for alu_seq_muldiv at WIDTH=32 and WIDTH=8,
//            directed cases plus randomized ops against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_muldiv;

  logic clk = 1'b0;
  logic reset;

  logic        s_start32, s_start8;
  logic [2:0]  s_op32, s_op8;
  logic [31:0] s_a32, s_b32;
  logic [7:0]  s_a8, s_b8;

  logic [31:0] r32, rh32;
  logic        z32, ov32, dz32, busy32, done32;
  logic [7:0]  r8, rh8;
  logic        z8, ov8, dz8, busy8, done8;

  int checks = 0;
  int errors = 0;

  logic [31:0] prev_lo [2];
  logic [31:0] prev_hi [2];

  // Clock.
  always #5 clk = ~clk;

  alu_seq_muldiv #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .i_start(s_start32), .i_op(s_op32),
    .i_first(s_a32), .i_second(s_b32), .o_result(r32), .o_result_hi(rh32),
    .o_zero(z32), .o_overflow(ov32), .o_div_by_zero(dz32),
    .o_busy(busy32), .o_done(done32)
  );

  alu_seq_muldiv #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .i_start(s_start8), .i_op(s_op8),
    .i_first(s_a8), .i_second(s_b8), .o_result(r8), .o_result_hi(rh8),
    .o_zero(z8), .o_overflow(ov8), .o_div_by_zero(dz8),
    .o_busy(busy8), .o_done(done8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_lo(input int sel);
    return (sel != 0) ? {24'd0, r8} : r32;
  endfunction
  function automatic logic [31:0] get_hi(input int sel);
    return (sel != 0) ? {24'd0, rh8} : rh32;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel != 0) ? done8 : done32;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy8 : busy32;
  endfunction
  function automatic logic get_zero(input int sel);
    return (sel != 0) ? z8 : z32;
  endfunction
  function automatic logic get_ov(input int sel);
    return (sel != 0) ? ov8 : ov32;
  endfunction
  function automatic logic get_dz(input int sel);
    return (sel != 0) ? dz8 : dz32;
  endfunction

  task automatic drive(input int sel, input logic st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel != 0) begin
      s_start8 = st; s_op8 = op; s_a8 = a[7:0]; s_b8 = b[7:0];
    end else begin
      s_start32 = st; s_op32 = op; s_a32 = a; s_b32 = b;
    end
  endtask

  // Reference model: plain integer arithmetic on w-bit operands.
  function automatic void model(input int w, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi,
                                output logic ov, output logic dbz, output int lat);
    longint unsigned mask, aa, bb, p;
    longint sa, sb, sr, smax, smin;
    mask = (64'd1 << w) - 64'd1;
    aa = 64'(a) & mask;
    bb = 64'(b) & mask;
    sa = longint'(aa);
    sb = longint'(bb);
    if (((aa >> (w - 1)) & 64'd1) != 0) sa = sa - (longint'(1) << w);
    if (((bb >> (w - 1)) & 64'd1) != 0) sb = sb - (longint'(1) << w);
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    lo = '0; hi = '0; ov = 1'b0; dbz = 1'b0; lat = 1;
    case (op)
      3'b000: lo = 32'(aa & bb);
      3'b001: lo = 32'(aa | bb);
      3'b010: begin
        sr = sa + sb; lo = 32'((aa + bb) & mask); ov = (sr > smax) || (sr < smin);
      end
      3'b110: begin
        sr = sa - sb; lo = 32'((aa - bb) & mask); ov = (sr > smax) || (sr < smin);
      end
      3'b111: lo = (sa < sb) ? 32'd1 : 32'd0;
      3'b011: begin
        p = aa * bb; lo = 32'(p & mask); hi = 32'((p >> w) & mask); lat = w + 1;
      end
      3'b100: begin
        if (bb == 0) begin
          lo = 32'(mask); hi = 32'(aa); dbz = 1'b1;
        end else begin
          lo = 32'(aa / bb); hi = 32'(aa % bb); lat = w + 1;
        end
      end
      default: ;
    endcase
  endfunction

  // Issue one op, optionally spraying ignored starts/operand changes while
  // busy, and check latency, hold-while-busy and final outputs.
  task automatic run(input int sel, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input bit noise, input bit b2b);
    logic [31:0] e_lo, e_hi;
    logic        e_ov, e_dbz;
    int          lat, cyc;
    model((sel != 0) ? 8 : 32, op, a, b, e_lo, e_hi, e_ov, e_dbz, lat);
    @(negedge clk);
    drive(sel, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, op, a, b);
    if (noise) drive(sel, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
    cyc = 1;
    while (!get_done(sel) && cyc < 100) begin
      chk("busy_flag", 64'(get_busy(sel)), 64'd1);
      chk("hold_lo", 64'(get_lo(sel)), 64'(prev_lo[sel]));
      chk("hold_hi", 64'(get_hi(sel)), 64'(prev_hi[sel]));
      if (noise) drive(sel, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
      @(posedge clk); #1;
      cyc++;
    end
    drive(sel, 1'b0, op, a, b);
    chk("latency", 64'(cyc), 64'(lat));
    chk("done", 64'(get_done(sel)), 64'd1);
    chk("busy_at_done", 64'(get_busy(sel)), 64'd0);
    chk("result", 64'(get_lo(sel)), 64'(e_lo));
    chk("result_hi", 64'(get_hi(sel)), 64'(e_hi));
    chk("zero", 64'(get_zero(sel)), 64'(e_lo == 32'd0));
    chk("overflow", 64'(get_ov(sel)), 64'(e_ov));
    chk("div_by_zero", 64'(get_dz(sel)), 64'(e_dbz));
    prev_lo[sel] = e_lo;
    prev_hi[sel] = e_hi;
    if (!b2b) begin
      @(posedge clk); #1;
      chk("done_pulse", 64'(get_done(sel)), 64'd0);
    end
  endtask

  task automatic check_reset_vals(input int sel);
    chk("rst_result", 64'(get_lo(sel)), 64'd0);
    chk("rst_result_hi", 64'(get_hi(sel)), 64'd0);
    chk("rst_zero", 64'(get_zero(sel)), 64'd1);
    chk("rst_overflow", 64'(get_ov(sel)), 64'd0);
    chk("rst_dbz", 64'(get_dz(sel)), 64'd0);
    chk("rst_busy", 64'(get_busy(sel)), 64'd0);
    chk("rst_done", 64'(get_done(sel)), 64'd0);
  endtask

  // Hard stop in case anything wedges.
  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Directed steps, then randomized ops.
  initial begin
    bit seen_done;
    reset = 1'b1;
    drive(0, 1'b0, 3'b000, 32'd0, 32'd0);
    drive(1, 1'b0, 3'b000, 32'd0, 32'd0);
    prev_lo[0] = '0; prev_hi[0] = '0; prev_lo[1] = '0; prev_hi[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals(0);
    check_reset_vals(1);
    @(negedge clk);
    reset = 1'b0;

    run(0, 3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run(0, 3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run(0, 3'b110, 32'd2, 32'd1, 1'b0, 1'b0);
    run(0, 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    run(0, 3'b011, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    run(0, 3'b100, 32'd100, 32'd7, 1'b1, 1'b0);
    run(0, 3'b100, 32'd5, 32'd0, 1'b0, 1'b0);
    run(0, 3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
    run(0, 3'b000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 1'b0);
    run(0, 3'b001, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0, 1'b0);
    run(0, 3'b110, 32'h8000_0000, 32'd1, 1'b0, 1'b0);
    // Back-to-back: next start asserted in the done cycle.
    run(0, 3'b010, 32'd10, 32'd20, 1'b0, 1'b1);
    run(0, 3'b011, 32'd12345, 32'd678, 1'b0, 1'b1);
    run(0, 3'b100, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b1);
    run(0, 3'b111, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Reset in the middle of a multiply: no done, reset values, then resume.
    @(negedge clk);
    drive(0, 1'b1, 3'b011, 32'hFFFF_FFFF, 32'd3);
    @(posedge clk); #1;
    drive(0, 1'b0, 3'b011, 32'hFFFF_FFFF, 32'd3);
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals(0);
    check_reset_vals(1);
    reset = 1'b0;
    prev_lo[0] = '0; prev_hi[0] = '0; prev_lo[1] = '0; prev_hi[1] = '0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen_done = seen_done | done32;
    end
    chk("no_done_after_abort", 64'(seen_done), 64'd0);
    run(0, 3'b010, 32'd3, 32'd4, 1'b0, 1'b0);

    // Narrow instance.
    run(1, 3'b011, 32'hFF, 32'hFF, 1'b1, 1'b0);
    run(1, 3'b010, 32'h7F, 32'h01, 1'b0, 1'b0);
    run(1, 3'b100, 32'hC8, 32'h0D, 1'b1, 1'b0);
    run(1, 3'b100, 32'h2A, 32'h00, 1'b0, 1'b0);

    // Randomized ops on both instances.
    for (int i = 0; i < 60; i++) begin
      int          sel;
      logic [2:0]  op;
      logic [31:0] a, b;
      sel = int'($urandom_range(0, 1));
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_000F;
      run(sel, op, a, b, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq_muldiv.md
# alu_seq_muldiv

Parametrised sequential ALU for the MIPS datapath, generalising the combinational 32-bit ALU to WIDTH bits and adding iterative unsigned multiply and divide with a start/busy/done handshake. Single-cycle ops complete in one clock; multiply and divide take WIDTH+1 clocks. Results are registered and held until the next accepted operation. It sits in EX beside the existing ALU and feeds the HI/LO register path.

## Interface
- WIDTH, 32: operand and result width; any value 4 or greater.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  request; accepted only when busy=0.
- op  in  3  operation code, sampled with start.
- first  in  WIDTH  operand A (dividend / multiplicand).
- second  in  WIDTH  operand B (divisor / multiplier).
- result  out  WIDTH  low word: ALU result, product[WIDTH-1:0], or quotient.
- result_hi  out  WIDTH  product[2*WIDTH-1:WIDTH] or remainder; 0 for single-cycle ops.
- zero  out  1  result==0 (low word only).
- overflow  out  1  signed overflow for add/sub; 0 otherwise.
- div_by_zero  out  1  last accepted op was divide with second==0.
- busy  out  1  multi-cycle op in progress.
- done  out  1  one-cycle pulse; results valid.

## Operation
- Opcodes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed; result=1 or 0), 011 MULTU, 100 DIVU, 101 reserved (treated as single-cycle, result=0, result_hi=0).
- ADD/SUB wrap modulo 2^WIDTH; overflow = operand signs equal (ADD) or differ (SUB) and result sign differs from first.
- States: IDLE, RUN. IDLE + start + (op MULTU, or DIVU with second!=0) -> RUN; all other accepted ops stay IDLE and complete immediately.
- MULTU: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator; exact unsigned product.
- DIVU: restoring, one quotient bit per cycle; quotient -> result, remainder -> result_hi.
- DIVU with second==0: completes as single-cycle; result=all ones, result_hi=first, div_by_zero=1.
- Iteration counter of clog2(WIDTH+1) bits counts WIDTH steps; RUN -> IDLE when the count reaches WIDTH.
- Operands are latched on acceptance; changes to first/second/op while busy have no effect.
- start while busy=1 is ignored (no queueing, no error).
- Outputs result, result_hi, zero, overflow, div_by_zero update only at completion and hold until the next completion.

## Timing
- Reset values: result=0, result_hi=0, zero=1, overflow=0, div_by_zero=0, busy=0, done=0, state=IDLE, counter=0.
- Start accepted at edge E0 (start=1, busy=0, reset=0).
- Single-cycle ops: after E0, done=1 for one cycle, outputs valid; busy stays 0. Latency 1.
- Multi-cycle ops: after E0, busy=1; iterations on E1..E_WIDTH; after E_WIDTH, busy=0, done=1, outputs valid. Latency WIDTH+1 (33 for WIDTH=32).
- Intermediate accumulator values never appear on the result outputs while busy=1; outputs show the previous completion's values.
- Back-to-back: start may be asserted in the done cycle (busy=0) and is accepted; done re-pulses per the new op's latency.
- Reset has priority over start and over RUN: reset mid-operation aborts, returns to reset values on the next edge, and produces no done.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 -> done one cycle later, result=0x80000000, overflow=1, zero=0.
- SUB 0xFFFFFFFF - 0xFFFFFFFF -> result=0, zero=1, overflow=0; SUB 2-1 -> result=1, zero=0; SLT 0xFFFFFFFF,1 -> result=1.
- MULTU 0xFFFFFFFF * 2 -> busy for 32 cycles, done on cycle 33, result_hi=0x00000001, result=0xFFFFFFFE; start pulses mid-run with other ops are ignored.
- DIVU 100 / 7 -> done after 33 cycles, result=14, result_hi=2, div_by_zero=0; DIVU 5 / 0 -> done after 1 cycle, result=0xFFFFFFFF, result_hi=5, div_by_zero=1.
- Reset asserted at iteration 10 of a MULTU -> next edge all outputs at reset values, no done; a new ADD 3+4 then returns result=7.
- WIDTH=8 instance: MULTU 0xFF*0xFF -> result_hi=0xFE, result=0x01 after 9 cycles; ADD 0x7F+0x01 -> result=0x80, overflow=1.
